// File: rtl/fir_in_ctrl.sv
// fir_in_ctrl: configuration and flow controller for the FIR input stage.
// Keeps the input stage's delay buffers from mixing samples of two configs.
// The stream is held off while in-flight samples drain, the stage is flushed,
// and only then is it released into RUN with the new config applied.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no config yet; stage held in flush, waiting for first config
// DRAIN | config change pending; stream stopped, in-flight samples exit
// FLUSH | new config applied; stage pointers/phase held cleared
// RUN   | samples stream through; a new config may be accepted
module fir_in_ctrl #(
    parameter int DRAIN_CYCLES = 8,
    parameter int FLUSH_CYCLES = 2,
    parameter int SHIFT_W      = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic               cfg_is_auto,
    input  logic [7:0]         cfg_delay,
    input  logic [SHIFT_W-1:0] cfg_shift,
    input  logic               s_valid,
    output logic               s_ready,
    output logic               fir_valid,
    output logic               is_auto,
    output logic [7:0]         delay,
    output logic [SHIFT_W-1:0] shift,
    output logic               flush,
    output logic               primed,
    output logic               busy
);

    localparam int MAX_CYC = (DRAIN_CYCLES > FLUSH_CYCLES) ? DRAIN_CYCLES : FLUSH_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2,
        RUN   = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   phase_cnt;
    logic               pend_is_auto;
    logic [7:0]         pend_delay;
    logic [SHIFT_W-1:0] pend_shift;
    logic [8:0]         scnt;
    logic [8:0]         warm;
    logic               phase_last;
    logic               enter_flush;

    // Per-state control levels decoded straight from the state register.
    assign flush     = (state == IDLE) || (state == FLUSH);
    assign s_ready   = (state == RUN);
    assign cfg_ready = (state == IDLE) || (state == RUN);
    assign busy      = (state == DRAIN) || (state == FLUSH);
    assign fir_valid = s_valid & s_ready;

    assign phase_last  = (phase_cnt == CNT_ONE);
    assign enter_flush = ((state == IDLE) && cfg_valid) || ((state == DRAIN) && phase_last);

    // Auto mode must fill both delay taps plus the alignment cycle first.
    assign warm   = is_auto ? {1'b0, delay[7:1], 1'b1} : 9'd0;
    assign primed = (state == RUN) && (scnt >= warm);

    // Sequencer: config capture, phase timing and state transitions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            phase_cnt    <= '0;
            pend_is_auto <= 1'b0;
            pend_delay   <= 8'd0;
            pend_shift   <= '0;
            is_auto      <= 1'b0;
            delay        <= 8'd0;
            shift        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        is_auto   <= cfg_is_auto;
                        delay     <= cfg_delay;
                        shift     <= cfg_shift;
                        phase_cnt <= FLUSH_LOAD;
                        state     <= FLUSH;
                    end
                end
                RUN: begin
                    if (cfg_valid) begin
                        pend_is_auto <= cfg_is_auto;
                        pend_delay   <= cfg_delay;
                        pend_shift   <= cfg_shift;
                        phase_cnt    <= DRAIN_LOAD;
                        state        <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (phase_last) begin
                        is_auto   <= pend_is_auto;
                        delay     <= pend_delay;
                        shift     <= pend_shift;
                        phase_cnt <= FLUSH_LOAD;
                        state     <= FLUSH;
                    end else begin
                        phase_cnt <= phase_cnt - CNT_ONE;
                    end
                end
                FLUSH: begin
                    if (phase_last) begin
                        state <= RUN;
                    end else begin
                        phase_cnt <= phase_cnt - CNT_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Accepted-sample counter for the current config, saturating at 511.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scnt <= 9'd0;
        end else if (enter_flush) begin
            scnt <= 9'd0;
        end else if (fir_valid && (scnt != 9'd511)) begin
            scnt <= scnt + 9'd1;
        end
    end

endmodule

// File: tb/tb_fir_in_ctrl.sv
// tb_fir_in_ctrl: directed bench for fir_in_ctrl with a sample scoreboard.
module tb_fir_in_ctrl;

    localparam int DRAIN = 8;
    localparam int FLUSH = 2;
    localparam int SW    = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_valid, cfg_ready, cfg_is_auto;
    logic [7:0]    cfg_delay;
    logic [SW-1:0] cfg_shift;
    logic          s_valid, s_ready, fir_valid;
    logic          is_auto;
    logic [7:0]    delay;
    logic [SW-1:0] shift;
    logic          flush, primed, busy;

    fir_in_ctrl #(.DRAIN_CYCLES(DRAIN), .FLUSH_CYCLES(FLUSH), .SHIFT_W(SW)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_is_auto(cfg_is_auto),
        .cfg_delay(cfg_delay), .cfg_shift(cfg_shift),
        .s_valid(s_valid), .s_ready(s_ready), .fir_valid(fir_valid),
        .is_auto(is_auto), .delay(delay), .shift(shift),
        .flush(flush), .primed(primed), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          a;
        logic [7:0]    d;
        logic [SW-1:0] s;
        logic          p;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model of the applied config and accepted-sample count.
    logic          exp_auto  = 1'b0;
    logic [7:0]    exp_delay = 8'd0;
    logic [SW-1:0] exp_shift = '0;
    int            w = 0;
    int            k = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t cur_exp();
        exp_t e;
        e.a = exp_auto;
        e.d = exp_delay;
        e.s = exp_shift;
        e.p = (k >= w);
        return e;
    endfunction

    // Monitor: every accepted sample must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && fir_valid) begin
            if (q.size() == 0) begin
                chk("sb_unexpected_fir_valid", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_is_auto", int'(is_auto), int'(e.a));
                chk("sb_delay",   int'(delay),   int'(e.d));
                chk("sb_shift",   int'(shift),   int'(e.s));
                chk("sb_primed",  int'(primed),  int'(e.p));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_sample(input bit v);
        s_valid = v;
        if (v) q.push_back(cur_exp());
        @(negedge clk);
        chk("fir_valid", int'(fir_valid), int'(v));
        chk("primed", int'(primed), int'(k >= w));
        if (v && k < 511) k++;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic apply_cfg(input bit a, input logic [7:0] d, input logic [SW-1:0] s,
                             input bit from_run, input bit with_sample, input bit inject);
        cfg_valid   = 1'b1;
        cfg_is_auto = a;
        cfg_delay   = d;
        cfg_shift   = s;
        if (with_sample) begin
            s_valid = 1'b1;
            q.push_back(cur_exp());
        end
        @(negedge clk);
        chk("cfg_ready_at_handshake", int'(cfg_ready), 1);
        tick();
        cfg_valid = 1'b0; s_valid = 1'b0;
        cfg_is_auto = 1'b0; cfg_delay = 8'd0; cfg_shift = '0;
        if (from_run) begin
            for (int i = 1; i <= DRAIN; i++) begin
                if (inject && i == 2) begin
                    cfg_valid = 1'b1; cfg_is_auto = ~a; cfg_delay = ~d; cfg_shift = ~s;
                end
                s_valid = inject;
                @(negedge clk);
                chk("drain_s_ready",   int'(s_ready),   0);
                chk("drain_fir_valid", int'(fir_valid), 0);
                chk("drain_flush",     int'(flush),     0);
                chk("drain_busy",      int'(busy),      1);
                chk("drain_cfg_ready", int'(cfg_ready), 0);
                chk("drain_old_delay", int'(delay),     int'(exp_delay));
                chk("drain_old_auto",  int'(is_auto),   int'(exp_auto));
                chk("drain_old_shift", int'(shift),     int'(exp_shift));
                tick();
                cfg_valid = 1'b0; s_valid = 1'b0;
            end
        end
        exp_auto = a; exp_delay = d; exp_shift = s;
        w = a ? 2 * int'(d[7:1]) + 1 : 0;
        k = 0;
        for (int i = 1; i <= FLUSH; i++) begin
            @(negedge clk);
            chk("flush_flush",   int'(flush),   1);
            chk("flush_s_ready", int'(s_ready), 0);
            chk("flush_busy",    int'(busy),    1);
            chk("flush_delay",   int'(delay),   int'(exp_delay));
            chk("flush_auto",    int'(is_auto), int'(exp_auto));
            chk("flush_shift",   int'(shift),   int'(exp_shift));
            tick();
        end
        @(negedge clk);
        chk("run_s_ready",   int'(s_ready),   1);
        chk("run_flush",     int'(flush),     0);
        chk("run_busy",      int'(busy),      0);
        chk("run_cfg_ready", int'(cfg_ready), 1);
        chk("run_primed",    int'(primed),    int'(w == 0));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_is_auto = 1'b0; cfg_delay = 8'd0;
        cfg_shift = '0; s_valid = 1'b1;
        #1;
        chk("rst_flush",     int'(flush),     1);
        chk("rst_cfg_ready", int'(cfg_ready), 1);
        chk("rst_s_ready",   int'(s_ready),   0);
        chk("rst_fir_valid", int'(fir_valid), 0);
        chk("rst_is_auto",   int'(is_auto),   0);
        chk("rst_delay",     int'(delay),     0);
        chk("rst_shift",     int'(shift),     0);
        chk("rst_primed",    int'(primed),    0);
        chk("rst_busy",      int'(busy),      0);
        s_valid = 1'b0;
        tick();
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_flush",   int'(flush),   1);
            chk("idle_s_ready", int'(s_ready), 0);
            tick();
        end

        // Pass-through config from IDLE, then a gapped stream.
        apply_cfg(1'b0, 8'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        drive_sample(1); drive_sample(0); drive_sample(1);
        drive_sample(1); drive_sample(0); drive_sample(1);

        // Auto mode, delay 10: warm-up of 11 samples.
        apply_cfg(1'b1, 8'd10, 5'd3, 1'b1, 1'b0, 1'b0);
        repeat (11) drive_sample(1);
        drive_sample(0);
        chk("primed_after_11", int'(primed), 1);

        // Minimum depth: one sample primes the stage.
        apply_cfg(1'b1, 8'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        drive_sample(1);
        drive_sample(0);

        // Maximum depth: 255 samples, counter well below saturation.
        apply_cfg(1'b1, 8'd255, 5'd31, 1'b1, 1'b0, 1'b0);
        repeat (255) drive_sample(1);
        drive_sample(0);
        drive_sample(1);

        // Sample and config in the same RUN cycle, plus an ignored config in DRAIN.
        apply_cfg(1'b0, 8'd4, 5'd1, 1'b1, 1'b1, 1'b1);
        drive_sample(1);

        // Reset in the middle of FLUSH.
        cfg_valid = 1'b1; cfg_is_auto = 1'b1; cfg_delay = 8'd20; cfg_shift = 5'd7;
        tick();
        cfg_valid = 1'b0;
        repeat (DRAIN) tick();
        @(negedge clk);
        chk("pre_rst_flush", int'(flush), 1);
        chk("pre_rst_delay", int'(delay), 20);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_flush",     int'(flush),     1);
        chk("midrst_delay",     int'(delay),     0);
        chk("midrst_is_auto",   int'(is_auto),   0);
        chk("midrst_shift",     int'(shift),     0);
        chk("midrst_s_ready",   int'(s_ready),   0);
        chk("midrst_cfg_ready", int'(cfg_ready), 1);
        chk("midrst_busy",      int'(busy),      0);
        tick();
        rst = 1'b0;
        exp_auto = 1'b0; exp_delay = 8'd0; exp_shift = '0; w = 0; k = 0;
        repeat (2) begin
            @(negedge clk);
            chk("post_rst_s_ready", int'(s_ready), 0);
            chk("post_rst_delay",   int'(delay),   0);
            tick();
        end

        // Auto mode, delay 6, random gaps: primed after the 7th sample.
        apply_cfg(1'b1, 8'd6, 5'd2, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 300 && k < 7; c++) drive_sample(bit'($urandom_range(0, 1)));
        chk("rand_reached_7", int'(k >= 7), 1);
        drive_sample(0);
        drive_sample(1);

        repeat (2) tick();
        chk("sb_queue_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fir_in_ctrl.md
# fir_in_ctrl

Configuration and flow controller for the FIR input stage. Accepts a configuration handshake (auto-correlation mode, delay, shift) and an upstream sample stream. Sequences drain, flush and run phases so that the input stage's delay buffers never mix samples from two configurations. Drives the input stage's control bundle (`is_auto`, `delay`, `shift`, `flush`) and its input valid, and reports when the stage's output becomes meaningful (`primed`).

## Interface
- `DRAIN_CYCLES`, default 8: cycles the stream is held off after a config change, so in-flight samples exit the input stage. Must be ≥1.
- `FLUSH_CYCLES`, default 2: cycles `flush` is held high before RUN. Must be ≥1.
- `SHIFT_W`, default 5: width of the multiplier shift field.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cfg_valid`  in  1  a configuration is offered.
- `cfg_ready`  out  1  controller can accept a configuration.
- `cfg_is_auto`  in  1  1 = auto-correlation mode, 0 = pass-through.
- `cfg_delay`  in  8  delay in samples. Bits [7:1] give the buffer depth; bit 0 adds one extra cycle of alignment.
- `cfg_shift`  in  SHIFT_W  post-multiply right shift.
- `s_valid`  in  1  upstream sample valid.
- `s_ready`  out  1  sample accepted this cycle when `s_valid & s_ready`.
- `fir_valid`  out  1  input-stage data valid; equals `s_valid & s_ready`, combinational.
- `is_auto`  out  1  latched mode bit.
- `delay`  out  8  latched delay.
- `shift`  out  SHIFT_W  latched shift.
- `flush`  out  1  clears the input stage's pointers and phase.
- `primed`  out  1  input-stage output is valid for the current configuration.
- `busy`  out  1  high in DRAIN or FLUSH.

## Operation
- FSM states: IDLE, DRAIN, FLUSH, RUN. A down-counter `phase_cnt` (width ≥ clog2 of max(DRAIN_CYCLES, FLUSH_CYCLES)+1) times DRAIN and FLUSH.
- Signal levels per state:
  - IDLE: `flush`=1, `s_ready`=0, `cfg_ready`=1.
  - DRAIN: `flush`=0, `s_ready`=0, `cfg_ready`=0.
  - FLUSH: `flush`=1, `s_ready`=0, `cfg_ready`=0.
  - RUN: `flush`=0, `s_ready`=1, `cfg_ready`=1.
- IDLE → FLUSH on a cfg handshake. Config fields are latched on the same edge; `phase_cnt` is loaded with FLUSH_CYCLES.
- RUN → DRAIN on a cfg handshake. The new config is captured into a pending register; the outputs `is_auto`/`delay`/`shift` keep the old values. `phase_cnt` is loaded with DRAIN_CYCLES.
- DRAIN → FLUSH when `phase_cnt` reaches 1. On that edge the pending config is copied to the outputs and `phase_cnt` is loaded with FLUSH_CYCLES.
- FLUSH → RUN when `phase_cnt` reaches 1.
- Sample counter `scnt` (9 bits):
  - Cleared on every entry to FLUSH.
  - Increments on each `fir_valid` in RUN; saturates at 511.
- Warm-up threshold: W = 2·`delay`[7:1] + 1 when `is_auto`=1, and W = 0 when `is_auto`=0.
- `primed` = (state==RUN) & (`scnt` ≥ W). This is a combinational decode of registers.
- `busy` = state ∈ {DRAIN, FLUSH}.
- Simultaneous events:
  - In RUN, `s_valid` and `cfg_valid` in the same cycle: the sample is accepted (`fir_valid`=1), the cfg is accepted, and the next state is DRAIN.
  - `cfg_valid` while not `cfg_ready` is ignored; there is no queueing.
- Any `cfg_delay` value is legal. `delay`[7:1]=0 gives W=1.

## Timing
- Reset values (asynchronous, take effect immediately): state=IDLE, `flush`=1, `cfg_ready`=1, `s_ready`=0, `fir_valid`=0, `is_auto`=0, `delay`=0, `shift`=0, `primed`=0, `busy`=0, `scnt`=0, pending=0.
- Reset asserted mid-operation aborts any phase; no partial config survives.
- Cfg accepted at edge T from IDLE:
  - `flush`=1 for cycles T+1 … T+FLUSH_CYCLES.
  - `s_ready`=1 from T+FLUSH_CYCLES+1.
- Cfg accepted at edge T from RUN:
  - `s_ready`=0 from T+1.
  - DRAIN covers T+1 … T+DRAIN_CYCLES.
  - New config appears on the outputs at T+DRAIN_CYCLES+1, which is also the first FLUSH cycle.
  - RUN resumes at T+DRAIN_CYCLES+FLUSH_CYCLES+1.
- Config outputs change only on the DRAIN→FLUSH or IDLE→FLUSH edge. They never change while `flush`=0.
- `primed` rises in the cycle after the W-th accepted sample. In pass-through mode it rises in the first RUN cycle.

## Test plan
- Reset, then cfg {auto=0, delay=0, shift=0} at cycle 5 → `flush` high through cycle 7, `s_ready` and `primed` =1 at cycle 8; streamed samples give `fir_valid`=`s_valid`.
- From RUN, cfg {auto=1, delay=8'd10, shift=3}, then continuous `s_valid` → outputs change only at the first FLUSH cycle; `primed` rises after exactly 11 accepted samples.
- Cfg delay=8'd0 in auto mode → `primed` after 1 sample; delay=8'd255 → after 255 samples, `scnt` saturation not reached.
- `cfg_valid` and `s_valid` high together in RUN → one `fir_valid` pulse, then `s_ready`=0 for DRAIN_CYCLES+FLUSH_CYCLES cycles; second `cfg_valid` during DRAIN is ignored.
- Assert `rst` during FLUSH → same cycle `flush`=1, `delay`=0, state IDLE, `s_ready`=0.
- Random `s_valid` with idle gaps in auto mode, delay=8'd6 → `primed` rises after the 7th accepted sample, independent of gap pattern.
